adc_conv_sequencer: RTL and testbench
=====================================

Name: adc_conv_sequencer

Overview:
Periodic ADC conversion scheduler. It issues a convst pulse of fixed width, waits a fixed conversion time, then requests a serial readout over a req/ack handshake and waits for read completion. It repeats this at a runtime-programmable period for a finite or continuous number of samples. It sits between the register interface (enable/period/num_samples) and the ADC pin driver / SPI reader, replacing ad-hoc delay chains.

Parameters:
CNT_WIDTH, 32, width of period, sample-count and internal counters
CONVST_CYCLES, 2, convst high time in clk cycles (>=1)
CONV_WAIT_CYCLES, 100, cycles from convst falling to read_req assertion (>=0)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  level; start on rising edge while IDLE, stop request when low
period  in  CNT_WIDTH  cycles between successive convst rising edges; latched at start
num_samples  in  CNT_WIDTH  samples per run; 0 = continuous; latched at start
convst  out  1  ADC conversion start, high CONVST_CYCLES cycles
read_req  out  1  readout request, held until read_ack
read_ack  in  1  reader accepts request (req&&ack in the same cycle = handshake)
read_done  in  1  one-cycle pulse, readout finished
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a finite run completes
overrun  out  1  sticky: a period tick was missed
sample_count  out  CNT_WIDTH  completed readouts in the current run

Behaviour:
- Reset (synchronous, one clk edge with reset=1): state IDLE; convst, read_req, busy, done, overrun = 0; sample_count = 0; counters = 0; enable edge detector primed so a held-high enable does not start. Reset mid-operation aborts immediately and read_req drops with no handshake.
- States: IDLE, CONVST, CONV_WAIT, READ_REQ, READ_WAIT, PERIOD_WAIT.
- IDLE: enable high at edge N with enable low at edge N-1 → latch period and num_samples, clear sample_count and overrun, enter CONVST. convst is high from cycle N+1.
- CONVST: convst=1 for exactly CONVST_CYCLES cycles → CONV_WAIT. If CONV_WAIT_CYCLES=0, go directly to READ_REQ.
- CONV_WAIT: CONV_WAIT_CYCLES cycles → READ_REQ.
- READ_REQ: read_req=1 until read_ack=1 (sampled same edge) → READ_WAIT. read_req is low the following cycle. read_done in READ_REQ is ignored.
- READ_WAIT: on read_done, sample_count+1, then decide in this order:
  - Finite and sample_count reaches num_samples → pulse done, go to IDLE.
  - enable low → go to IDLE with no done pulse.
  - Period tick on the same cycle → go to CONVST.
  - Otherwise → go to PERIOD_WAIT.
- PERIOD_WAIT: on period tick → CONVST. If enable is low, go to IDLE immediately.
- Period timer:
  - Reloads on every cycle convst rises.
  - The tick fires period cycles after that rise.
  - Effective period = max(latched period, 1).
  - A tick in CONVST/CONV_WAIT/READ_REQ, or in READ_WAIT without a coincident read_done, sets overrun (sticky until next start). That tick is dropped; the next conversion waits for the following tick.
- enable low mid-sample: the current sample completes through read_done; no new convst follows.
- After a finite run completes: stays IDLE until a fresh enable rising edge.
- sample_count wraps modulo 2^CNT_WIDTH in continuous mode. done never pulses when num_samples=0.
- done and the IDLE transition occur on the same edge. busy drops the cycle done is high.

Test Plan:
- CONVST_CYCLES=2, CONV_WAIT_CYCLES=4, period=20, num_samples=3; reader acks immediately and pulses read_done 3 cycles after ack → convst rises at start+1, +21, +41, 2 cycles wide each; read_req rises 4 cycles after convst falls; done pulses once; sample_count=3; overrun=0; busy low after done.
- Same setup, read_done delayed 30 cycles → overrun=1 after first tick miss; convst spacing 40 cycles; sample_count still reaches 3.
- num_samples=0, period=15, enable dropped during CONV_WAIT of sample 5 → sample 5 read completes; no sixth convst; no done; IDLE; sample_count=5.
- read_ack held low 10 cycles → read_req stays high 10+1 cycles; drops the cycle after ack; read_done pulses during READ_REQ are not counted.
- Reset asserted for 1 cycle while read_req=1 → next cycle all outputs 0, IDLE; enable still high does not restart until toggled low then high.
- period=0 and period=1 → no hang; overrun set on first sample; conversions proceed back-to-back limited by the handshake.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: periodic ADC scheduler issuing convst, a fixed conversion wait,
// then a req/ack readout, repeated at a programmable period for a finite or endless run.
module adc_conv_sequencer #(
    parameter int CNT_WIDTH        = 32,
    parameter int CONVST_CYCLES    = 2,
    parameter int CONV_WAIT_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] num_samples,
    output logic                 convst,
    output logic                 read_req,
    input  logic                 read_ack,
    input  logic                 read_done,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] sample_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_CONVST, S_CONV_WAIT, S_READ_REQ, S_READ_WAIT, S_PERIOD_WAIT
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CS_LAST = CNT_WIDTH'(CONVST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CW_LAST = CNT_WIDTH'(CONV_WAIT_CYCLES == 0 ? 0 : CONV_WAIT_CYCLES - 1);

    state_t               state, next_state;
    logic                 enable_q, start, tick, missed, reload, last_sample, finish_run;
    logic [CNT_WIDTH-1:0] phase, ptmr, per_q, num_q, per_src, per_m1;

    assign start       = state == S_IDLE && enable && !enable_q;
    assign tick        = state != S_IDLE && ptmr == '0;
    assign missed      = tick && state != S_PERIOD_WAIT && !(state == S_READ_WAIT && read_done);
    assign last_sample = num_q != '0 && sample_count + 1'b1 == num_q;
    // the period timer counts down to zero, so load max(period,1)-1
    assign per_src     = start ? period : per_q;
    assign per_m1      = per_src == '0 ? '0 : per_src - 1'b1;
    assign reload      = tick || (next_state == S_CONVST && state != S_CONVST);

    always_comb begin
        next_state = state;
        finish_run = 1'b0;
        convst     = state == S_CONVST;
        read_req   = state == S_READ_REQ;
        busy       = state != S_IDLE;
        case (state)
            S_IDLE:        next_state = start ? S_CONVST : S_IDLE;
            S_CONVST:      next_state = phase != CS_LAST ? S_CONVST :
                                        CONV_WAIT_CYCLES == 0 ? S_READ_REQ : S_CONV_WAIT;
            S_CONV_WAIT:   next_state = phase == CW_LAST ? S_READ_REQ : S_CONV_WAIT;
            S_READ_REQ:    next_state = read_ack ? S_READ_WAIT : S_READ_REQ;
            S_READ_WAIT: begin
                finish_run = read_done && last_sample;
                next_state = !read_done ? S_READ_WAIT :
                             (last_sample || !enable) ? S_IDLE :
                             tick ? S_CONVST : S_PERIOD_WAIT;
            end
            S_PERIOD_WAIT: next_state = !enable ? S_IDLE : tick ? S_CONVST : S_PERIOD_WAIT;
            default:       next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            enable_q     <= 1'b1;
            phase        <= '0;
            ptmr         <= '0;
            per_q        <= '0;
            num_q        <= '0;
            sample_count <= '0;
            overrun      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= next_state;
            enable_q     <= enable;
            done         <= finish_run;
            phase        <= (next_state != state || state == S_IDLE) ? '0 : phase + 1'b1;
            ptmr         <= reload ? per_m1 : state == S_IDLE ? ptmr : ptmr - 1'b1;
            per_q        <= start ? period : per_q;
            num_q        <= start ? num_samples : num_q;
            sample_count <= start ? '0 :
                            (state == S_READ_WAIT && read_done) ? sample_count + 1'b1 : sample_count;
            overrun      <= start ? 1'b0 : overrun | missed;
        end
    end
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: scoreboard bench; expected convst rise and done cycles are queued
// at each start and popped as the DUT produces them, with a behavioural ADC reader.
module tb_adc_conv_sequencer;
    localparam int W = 32;

    logic         clk = 0, reset = 1, enable = 0, read_ack = 0, read_done = 0;
    logic [W-1:0] period = 0, num_samples = 0, sample_count;
    logic         convst, read_req, busy, done, overrun;

    int cyc = 0, n_chk = 0, n_fail = 0, k = 0;
    int ack_delay = 0, done_delay = 3, req_age = 0, rd_cnt = 0;
    int rise_c = 0, req_c = 0;
    bit spurious = 0, chk_len = 1;
    logic cv_p = 0, rq_p = 0;
    int exp_rise[$], exp_done[$];

    adc_conv_sequencer #(.CNT_WIDTH(W), .CONVST_CYCLES(2), .CONV_WAIT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .num_samples(num_samples),
        .convst(convst), .read_req(read_req), .read_ack(read_ack), .read_done(read_done),
        .busy(busy), .done(done), .overrun(overrun), .sample_count(sample_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reader: acks after ack_delay cycles of read_req, pulses read_done done_delay cycles after ack
    initial forever begin
        @(posedge clk); #1;
        read_ack = 0;
        read_done = 0;
        if (rd_cnt > 0) begin rd_cnt--; read_done = (rd_cnt == 0); end
        if (read_req) begin
            if (spurious && req_age == 2) read_done = 1;
            if (req_age == ack_delay) begin read_ack = 1; rd_cnt = done_delay; end
            req_age++;
        end else req_age = 0;
    end

    always @(negedge clk) begin
        if (convst && !cv_p) begin
            check("convst_expected", exp_rise.size() > 0, 1);
            if (exp_rise.size() > 0) check("convst_rise", cyc, exp_rise.pop_front());
            rise_c = cyc;
        end
        if (!convst && cv_p) check("convst_width", cyc - rise_c, 2);
        if (read_req && !rq_p) begin check("req_latency", cyc - rise_c, 6); req_c = cyc; end
        if (!read_req && rq_p && chk_len) check("req_len", cyc - req_c, ack_delay + 1);
        if (done) begin
            check("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) check("done_cycle", cyc, exp_done.pop_front());
            check("busy_at_done", busy, 0);
        end
        cv_p = convst;
        rq_p = read_req;
    end

    task automatic run_start(input int p, input int n);
        enable = 0;
        @(negedge clk);
        period = p;
        num_samples = n;
        enable = 1;
        k = cyc;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < max);
        check("idle_timeout", busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_convst", convst, 0);
        check("rst_read_req", read_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_count", sample_count, 0);
        reset = 0;
        // finite run, fast reader
        run_start(20, 3);
        exp_rise.push_back(k + 1); exp_rise.push_back(k + 21); exp_rise.push_back(k + 41);
        exp_done.push_back(k + 51);
        wait_idle(200);
        repeat (10) @(negedge clk);
        check("t1_count", sample_count, 3);
        check("t1_overrun", overrun, 0);
        check("t1_rise_left", exp_rise.size(), 0);
        check("t1_done_left", exp_done.size(), 0);
        // slow reader misses the first tick
        done_delay = 30;
        run_start(20, 3);
        exp_rise.push_back(k + 1); exp_rise.push_back(k + 41); exp_rise.push_back(k + 81);
        exp_done.push_back(k + 118);
        while (cyc < k + 20) @(negedge clk);
        check("t2_overrun_early", overrun, 0);
        while (cyc < k + 22) @(negedge clk);
        check("t2_overrun_set", overrun, 1);
        wait_idle(300);
        check("t2_count", sample_count, 3);
        check("t2_overrun", overrun, 1);
        check("t2_rise_left", exp_rise.size(), 0);
        // continuous run stopped during conversion wait of sample 5
        done_delay = 3;
        run_start(15, 0);
        for (int i = 0; i < 5; i++) exp_rise.push_back(k + 1 + 15 * i);
        while (cyc < k + 64) @(negedge clk);
        enable = 0;
        wait_idle(100);
        repeat (20) @(negedge clk);
        check("t3_count", sample_count, 5);
        check("t3_overrun", overrun, 0);
        check("t3_rise_left", exp_rise.size(), 0);
        // slow ack, read_done during READ_REQ is ignored
        ack_delay = 10;
        spurious = 1;
        run_start(20, 1);
        exp_rise.push_back(k + 1);
        exp_done.push_back(k + 21);
        wait_idle(100);
        check("t4_count", sample_count, 1);
        check("t4_overrun", overrun, 0);
        check("t4_done_left", exp_done.size(), 0);
        spurious = 0;
        // reset while read_req is high, enable held high
        ack_delay = 50;
        chk_len = 0;
        run_start(20, 0);
        exp_rise.push_back(k + 1);
        for (int n = 0; n < 50 && !read_req; n++) @(negedge clk);
        check("t5_req_seen", read_req, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("t5_convst", convst, 0);
        check("t5_read_req", read_req, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_overrun", overrun, 0);
        check("t5_count", sample_count, 0);
        repeat (5) @(negedge clk);
        check("t5_no_restart", busy, 0);
        ack_delay = 0;
        run_start(20, 1);
        chk_len = 1;
        exp_rise.push_back(k + 1);
        exp_done.push_back(k + 11);
        wait_idle(100);
        check("t5_restart_count", sample_count, 1);
        // degenerate periods run back-to-back
        for (int p = 0; p < 2; p++) begin
            run_start(p, 3);
            exp_rise.push_back(k + 1); exp_rise.push_back(k + 11); exp_rise.push_back(k + 21);
            exp_done.push_back(k + 31);
            wait_idle(200);
            check("t6_count", sample_count, 3);
            check("t6_overrun", overrun, 1);
            check("t6_done_left", exp_done.size(), 0);
        end
        check("final_rise_left", exp_rise.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
